// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single-port data memory (DMem) between two requesters:
//   requester 0 (core load/store unit) and requester 1 (debug/DMA port).
//   Requests are arbitrated round-robin, one transaction is in flight at a
//   time, and each transaction takes IDLE -> ACCESS -> RESP (minimum three
//   cycles). The DMem strobes and operands are driven from registers during
//   the single ACCESS cycle; the load result (or store acknowledge) is held
//   on the owner's response port until the owner takes it.
//
// Ports
//   clk, rst_n                 clock; synchronous active-low reset
//   m{0,1}_req_valid/ready     request handshake (fields held until ready)
//   m{0,1}_req_we/funct3/addr/wdata  request fields (store when we=1)
//   m{0,1}_rsp_valid/ready     response handshake
//   m{0,1}_rsp_rdata/err       load result (0 for stores) / access rejected
//   dmem_funct3/address/MemRead/MemWrite/rs   to DMem, live only in ACCESS
//   dmem_rd                    from DMem, combinational while MemRead=1
//
// Configuration
//   DMEM_ARB_ACCESS_CHECK_EN   when defined, misaligned halfword/word
//                              accesses and illegal funct3 codes are rejected
//                              at handshake: the ACCESS cycle still happens
//                              with both strobes low and the response carries
//                              err=1, rdata=0. When undefined, every request
//                              is forwarded unchanged and err is always 0.
module dmem_arbiter #(
  parameter int ADDLEN = 32,
  parameter int VLEN   = 32,
  parameter int F3     = 3
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              m0_req_valid,
  output logic              m0_req_ready,
  input  logic              m0_req_we,
  input  logic [F3-1:0]     m0_req_funct3,
  input  logic [ADDLEN-1:0] m0_req_addr,
  input  logic [VLEN-1:0]   m0_req_wdata,
  output logic              m0_rsp_valid,
  input  logic              m0_rsp_ready,
  output logic [VLEN-1:0]   m0_rsp_rdata,
  output logic              m0_rsp_err,

  input  logic              m1_req_valid,
  output logic              m1_req_ready,
  input  logic              m1_req_we,
  input  logic [F3-1:0]     m1_req_funct3,
  input  logic [ADDLEN-1:0] m1_req_addr,
  input  logic [VLEN-1:0]   m1_req_wdata,
  output logic              m1_rsp_valid,
  input  logic              m1_rsp_ready,
  output logic [VLEN-1:0]   m1_rsp_rdata,
  output logic              m1_rsp_err,

  output logic [F3-1:0]     dmem_funct3,
  output logic [ADDLEN-1:0] dmem_address,
  output logic              dmem_MemRead,
  output logic              dmem_MemWrite,
  output logic [VLEN-1:0]   dmem_rs,
  input  logic [VLEN-1:0]   dmem_rd
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Latched transaction
  logic              owner_q;
  logic              we_q;
  logic              reject_q;
  logic [F3-1:0]     funct3_q;
  logic [ADDLEN-1:0] addr_q;
  logic [VLEN-1:0]   wdata_q;
  // Response register
  logic [VLEN-1:0]   rdata_q;
  logic              err_q;
  // Requester granted by the most recent handshake; 1 after reset so that
  // requester 0 wins the first tie.
  logic              last_grant;

  logic              gnt_any;
  logic              gnt_id;
  logic              sel_we;
  logic [F3-1:0]     sel_funct3;
  logic [ADDLEN-1:0] sel_addr;
  logic [VLEN-1:0]   sel_wdata;
  logic              reject_d;
  logic              owner_rsp_ready;
  logic              in_access;
  logic              in_resp;

  // Arbitration only exists in IDLE, so a request arriving while busy simply
  // waits. Ready is asserted only to a valid requester, hence gnt_any is the
  // handshake itself.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    gnt_any = 1'b0;
    gnt_id  = 1'b0;
    if (state_q == IDLE) begin
      if (m0_req_valid && m1_req_valid) begin
        gnt_any = 1'b1;
        gnt_id  = ~last_grant;
      end else if (m0_req_valid) begin
        gnt_any = 1'b1;
        gnt_id  = 1'b0;
      end else if (m1_req_valid) begin
        gnt_any = 1'b1;
        gnt_id  = 1'b1;
      end
    end
  end

  assign m0_req_ready = gnt_any & ~gnt_id;
  assign m1_req_ready = gnt_any &  gnt_id;

  // Fields of the granted requester
  assign sel_we     = gnt_id ? m1_req_we     : m0_req_we;
  assign sel_funct3 = gnt_id ? m1_req_funct3 : m0_req_funct3;
  assign sel_addr   = gnt_id ? m1_req_addr   : m0_req_addr;
  assign sel_wdata  = gnt_id ? m1_req_wdata  : m0_req_wdata;

`ifdef DMEM_ARB_ACCESS_CHECK_EN
  // Natural alignment and legal width codes; lbu/lhu have no store form.
  always_comb begin
    reject_d = 1'b0;
    case (sel_funct3)
      3'b000:  reject_d = 1'b0;
      3'b001:  reject_d = sel_addr[0];
      3'b010:  reject_d = (sel_addr[1:0] != 2'b00);
      3'b100:  reject_d = sel_we;
      3'b101:  reject_d = sel_we | sel_addr[0];
      default: reject_d = 1'b1;
    endcase
  end
`else
  assign reject_d = 1'b0;
`endif

  assign owner_rsp_ready = owner_q ? m1_rsp_ready : m0_rsp_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_any) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    if (owner_rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q    <= IDLE;
      last_grant <= 1'b1;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      reject_q   <= 1'b0;
      funct3_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (gnt_any) begin
        owner_q    <= gnt_id;
        last_grant <= gnt_id;
        we_q       <= sel_we;
        funct3_q   <= sel_funct3;
        addr_q     <= sel_addr;
        wdata_q    <= sel_wdata;
        reject_q   <= reject_d;
      end
      // The load result is taken at the end of ACCESS while MemRead is high;
      // stores and rejected accesses answer with zero data.
      if (state_q == ACCESS) begin
        rdata_q <= (we_q || reject_q) ? '0 : dmem_rd;
        err_q   <= reject_q;
      end
    end
  end

  assign in_access = (state_q == ACCESS);
  assign in_resp   = (state_q == RESP);

  // A store in ACCESS when reset asserts still commits: DMem samples this
  // registered-state strobe on the same edge that applies the reset.
  assign dmem_MemWrite = in_access &  we_q & ~reject_q;
  assign dmem_MemRead  = in_access & ~we_q & ~reject_q;
  assign dmem_address  = in_access ? addr_q   : '0;
  assign dmem_funct3   = in_access ? funct3_q : '0;
  assign dmem_rs       = in_access ? wdata_q  : '0;

  assign m0_rsp_valid = in_resp & ~owner_q;
  assign m1_rsp_valid = in_resp &  owner_q;
  assign m0_rsp_rdata = m0_rsp_valid ? rdata_q : '0;
  assign m1_rsp_rdata = m1_rsp_valid ? rdata_q : '0;
  assign m0_rsp_err   = m0_rsp_valid & err_q;
  assign m1_rsp_err   = m1_rsp_valid & err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter. A byte-addressed DMem model serves
// the DUT; a separate reference byte memory plus simple rules (round-robin
// on ties, three-cycle transaction, response to owner only) predict every
// observable value. Honors DMEM_ARB_ACCESS_CHECK_EN when defined.
module tb_dmem_arbiter;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       req_valid, req_ready, req_we;
  logic [1:0][2:0]  req_f3;
  logic [1:0][31:0] req_addr, req_wdata;
  logic [1:0]       rsp_valid, rsp_ready, rsp_err;
  logic [1:0][31:0] rsp_rdata;
  logic [2:0]       dmem_funct3;
  logic [31:0]      dmem_address, dmem_rs, dmem_rd;
  logic             dmem_MemRead, dmem_MemWrite;

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_valid(req_valid[0]), .m0_req_ready(req_ready[0]), .m0_req_we(req_we[0]),
    .m0_req_funct3(req_f3[0]), .m0_req_addr(req_addr[0]), .m0_req_wdata(req_wdata[0]),
    .m0_rsp_valid(rsp_valid[0]), .m0_rsp_ready(rsp_ready[0]),
    .m0_rsp_rdata(rsp_rdata[0]), .m0_rsp_err(rsp_err[0]),
    .m1_req_valid(req_valid[1]), .m1_req_ready(req_ready[1]), .m1_req_we(req_we[1]),
    .m1_req_funct3(req_f3[1]), .m1_req_addr(req_addr[1]), .m1_req_wdata(req_wdata[1]),
    .m1_rsp_valid(rsp_valid[1]), .m1_rsp_ready(rsp_ready[1]),
    .m1_rsp_rdata(rsp_rdata[1]), .m1_rsp_err(rsp_err[1]),
    .dmem_funct3(dmem_funct3), .dmem_address(dmem_address),
    .dmem_MemRead(dmem_MemRead), .dmem_MemWrite(dmem_MemWrite),
    .dmem_rs(dmem_rs), .dmem_rd(dmem_rd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  bit exp_last = 1'b1;   // model of which requester won the last grant

`ifdef DMEM_ARB_ACCESS_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic [138:0] all_out;
  assign all_out = {req_ready, rsp_valid, rsp_err, rsp_rdata, dmem_MemRead,
                    dmem_MemWrite, dmem_address, dmem_funct3, dmem_rs};

  // ---------------- DMem model and reference memory ----------------
  logic [7:0] dm      [256] = '{default: 8'h00};
  logic [7:0] ref_mem [256] = '{default: 8'h00};

  function automatic logic [31:0] ext_load(logic [2:0] f3, logic [7:0] b0,
                                           logic [7:0] b1, logic [7:0] b2, logic [7:0] b3);
    case (f3)
      3'b000:  return {{24{b0[7]}}, b0};
      3'b001:  return {{16{b1[7]}}, b1, b0};
      3'b100:  return {24'h0, b0};
      3'b101:  return {16'h0, b1, b0};
      default: return {b3, b2, b1, b0};
    endcase
  endfunction

  logic [7:0] da;
  always_comb begin
    da = dmem_address[7:0];
    if (dmem_MemRead)
      dmem_rd = ext_load(dmem_funct3, dm[da], dm[8'(da + 8'd1)], dm[8'(da + 8'd2)], dm[8'(da + 8'd3)]);
    else
      dmem_rd = 32'hDEAD_BEEF;
  end

  always @(posedge clk) begin
    if (dmem_MemWrite) begin
      dm[da] <= dmem_rs[7:0];
      if (dmem_funct3[1:0] != 2'b00) dm[8'(da + 8'd1)] <= dmem_rs[15:8];
      if (dmem_funct3[1:0] == 2'b10) begin
        dm[8'(da + 8'd2)] <= dmem_rs[23:16];
        dm[8'(da + 8'd3)] <= dmem_rs[31:24];
      end
    end
  end

  function automatic logic [31:0] ref_load(logic [2:0] f3, logic [31:0] a);
    logic [7:0] i;
    i = a[7:0];
    return ext_load(f3, ref_mem[i], ref_mem[8'(i + 8'd1)], ref_mem[8'(i + 8'd2)], ref_mem[8'(i + 8'd3)]);
  endfunction

  task automatic ref_store(logic [2:0] f3, logic [31:0] a, logic [31:0] d);
    logic [7:0] i;
    i = a[7:0];
    for (int k = 0; k < 4; k++)
      if (k < (1 << f3[1:0])) ref_mem[8'(i + 8'(k))] = d[8*k +: 8];
  endtask

  function automatic bit exp_reject(bit we, logic [2:0] f3, logic [31:0] a);
    bit bad;
    case (f3)
      3'b000:  bad = 1'b0;
      3'b001:  bad = a[0];
      3'b010:  bad = (a[1:0] != 2'b00);
      3'b100:  bad = we;
      3'b101:  bad = we | a[0];
      default: bad = 1'b1;
    endcase
    return CHK && bad;
  endfunction

  typedef struct {
    int          port;
    bit          we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
    int          hs;
  } txn_t;

  // ---------------- stimulus helpers (no checking inside) ----------------
  task automatic drive(int p, bit we, logic [2:0] f3, logic [31:0] a, logic [31:0] d);
    req_valid[p] = 1'b1; req_we[p] = we; req_f3[p] = f3;
    req_addr[p]  = a;    req_wdata[p] = d;
  endtask

  task automatic new_req(int p);
    bit we;
    logic [2:0] f3;
    logic [31:0] a;
    logic [2:0] ld_codes [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    we = 1'($urandom_range(0, 1));
    f3 = ld_codes[$urandom_range(0, we ? 2 : 4)];
    a  = 32'($urandom_range(0, 63));
    if (f3[1:0] == 2'b01) a[0] = 1'b0;
    if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
    drive(p, we, f3, a, $urandom);
  endtask

  // Waits for ready on port p, lets the handshake edge pass, drops valid.
  // Returns #1 after the handshake edge (inside the ACCESS cycle).
  task automatic wait_hs(int p, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready[p]) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    req_valid[p] = 1'b0;
  endtask

  // Waits (at negedges) until port p shows a response.
  task automatic wait_rsp(int p, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid[p]) begin ok = 1'b1; break; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; req_valid = '0; rsp_ready = '0;
    req_we = '0; req_f3 = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (all_out !== '0) $display("FAIL reset_outputs got=%h exp=0", all_out); else n_pass++;
    rst_n = 1'b1;
    exp_last = 1'b1;
    drive(0, 1'b0, 3'b010, 32'h0, 32'h0);
    drive(1, 1'b0, 3'b010, 32'h4, 32'h0);
    #1;
    n_checks++; if (req_ready !== 2'b01) $display("FAIL reset_first_tie got=%b exp=01", req_ready); else n_pass++;
    req_valid = '0;
  endtask

  task automatic test_store();
    bit ok;
    rsp_ready = 2'b11;
    @(posedge clk); #1;
    drive(0, 1'b1, 3'b010, 32'h0, 32'hAABB_CCDD);
    wait_hs(0, ok);
    n_checks++; if (!ok) $display("FAIL store_hs got=timeout exp=ready"); else n_pass++;
    exp_last = 1'b0;
    ref_store(3'b010, 32'h0, 32'hAABB_CCDD);
    @(negedge clk);   // ACCESS
    n_checks++; if ({dmem_MemWrite, dmem_MemRead, dmem_funct3, dmem_address, dmem_rs} !== {2'b10, 3'b010, 32'h0, 32'hAABB_CCDD})
      $display("FAIL store_access got=%b%b %b %h %h exp=10 010 0 aabbccdd", dmem_MemWrite, dmem_MemRead, dmem_funct3, dmem_address, dmem_rs);
    else n_pass++;
    n_checks++; if (rsp_valid !== 2'b00) $display("FAIL store_early_rsp got=%b exp=00", rsp_valid); else n_pass++;
    @(negedge clk);   // RESP
    n_checks++; if ({dmem_MemWrite, rsp_valid, rsp_err[0], rsp_rdata[0]} !== {1'b0, 2'b01, 1'b0, 32'h0})
      $display("FAIL store_resp got=we%b v%b e%b d%h exp=we0 v01 e0 d0", dmem_MemWrite, rsp_valid, rsp_err[0], rsp_rdata[0]);
    else n_pass++;
    @(negedge clk);   // back in IDLE
    n_checks++; if (rsp_valid !== 2'b00) $display("FAIL store_rsp_drop got=%b exp=00", rsp_valid); else n_pass++;
  endtask

  task automatic test_loads();
    logic [2:0]  f3s  [5] = '{3'b010, 3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] exps [5] = '{32'hAABB_CCDD, 32'hFFFF_FFDD, 32'h0000_00DD, 32'hFFFF_CCDD, 32'h0000_CCDD};
    bit ok;
    for (int i = 0; i < 5; i++) begin
      drive(0, 1'b0, f3s[i], 32'h0, 32'h0);
      wait_hs(0, ok);
      wait_rsp(0, ok);
      n_checks++; if (!ok || rsp_rdata[0] !== exps[i] || rsp_err[0] !== 1'b0)
        $display("FAIL load_f3_%b got=%h err=%b exp=%h err=0", f3s[i], rsp_rdata[0], rsp_err[0], exps[i]);
      else n_pass++;
      @(posedge clk); #1;
    end
    exp_last = 1'b0;
  endtask

  task automatic test_hold();
    bit ok;
    logic [31:0] exp_d, first_d;
    rsp_ready = 2'b01;
    drive(1, 1'b0, 3'b010, 32'h0, 32'h0);
    exp_d = ref_load(3'b010, 32'h0);
    wait_hs(1, ok);
    n_checks++; if (!ok) $display("FAIL hold_hs got=timeout exp=ready"); else n_pass++;
    exp_last = 1'b1;
    drive(0, 1'b0, 3'b001, 32'h2, 32'h0);   // competing request must wait
    @(negedge clk);   // ACCESS
    first_d = exp_d;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++; if ({rsp_valid, rsp_rdata[1], req_ready, dmem_MemRead, dmem_MemWrite} !== {2'b10, first_d, 2'b00, 2'b00})
        $display("FAIL hold_cycle%0d got=v%b d%h r%b s%b%b exp=v10 d%h r00 s00", i, rsp_valid, rsp_rdata[1], req_ready, dmem_MemRead, dmem_MemWrite, first_d);
      else n_pass++;
    end
    rsp_ready = 2'b11;
    @(negedge clk);
    n_checks++; if ({rsp_valid, req_ready} !== 4'b0001) $display("FAIL hold_release got=v%b r%b exp=v00 r01", rsp_valid, req_ready); else n_pass++;
    exp_d = ref_load(3'b001, 32'h2);
    wait_hs(0, ok);
    exp_last = 1'b0;
    wait_rsp(0, ok);
    n_checks++; if (!ok || rsp_rdata[0] !== exp_d) $display("FAIL hold_waiter got=%h exp=%h", rsp_rdata[0], exp_d); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_misaligned();
    bit ok, rej;
    logic [31:0] exp_d;
    rej   = exp_reject(1'b0, 3'b010, 32'h2);
    exp_d = rej ? 32'h0 : ref_load(3'b010, 32'h2);
    drive(0, 1'b0, 3'b010, 32'h2, 32'h0);
    wait_hs(0, ok);
    exp_last = 1'b0;
    @(negedge clk);   // ACCESS
    n_checks++; if (dmem_MemRead !== !rej) $display("FAIL misaligned_memread got=%b exp=%b", dmem_MemRead, !rej); else n_pass++;
    wait_rsp(0, ok);
    n_checks++; if (!ok || rsp_err[0] !== rej || rsp_rdata[0] !== exp_d)
      $display("FAIL misaligned_rsp got=err%b d%h exp=err%b d%h", rsp_err[0], rsp_rdata[0], rej, exp_d);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [31:0] v;
    v = $urandom;
    // Store whose ACCESS cycle sees reset still commits.
    drive(0, 1'b1, 3'b010, 32'h8, v);
    wait_hs(0, ok);
    rst_n = 1'b0;
    ref_store(3'b010, 32'h8, v);
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (all_out !== '0) $display("FAIL reset_in_access got=%h exp=0", all_out); else n_pass++;
    rst_n = 1'b1;
    exp_last = 1'b1;
    drive(1, 1'b0, 3'b010, 32'h8, 32'h0);
    wait_hs(1, ok);
    exp_last = 1'b1;
    wait_rsp(1, ok);
    n_checks++; if (!ok || rsp_rdata[1] !== v) $display("FAIL reset_store_commit got=%h exp=%h", rsp_rdata[1], v); else n_pass++;
    @(posedge clk); #1;
    // Reset during RESP drops the pending response.
    rsp_ready = 2'b00;
    drive(0, 1'b0, 3'b010, 32'h8, 32'h0);
    wait_hs(0, ok);
    @(negedge clk);   // ACCESS
    @(negedge clk);   // RESP
    n_checks++; if (rsp_valid !== 2'b01) $display("FAIL reset_pre_resp got=%b exp=01", rsp_valid); else n_pass++;
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (all_out !== '0) $display("FAIL reset_in_resp got=%h exp=0", all_out); else n_pass++;
    rst_n = 1'b1;
    exp_last = 1'b1;
    drive(0, 1'b0, 3'b010, 32'h0, 32'h0);
    drive(1, 1'b0, 3'b010, 32'h4, 32'h0);
    #1;
    n_checks++; if (req_ready !== 2'b01) $display("FAIL reset_tie_after got=%b exp=01", req_ready); else n_pass++;
    req_valid = '0;
    rsp_ready = 2'b11;
  endtask

  // Cycle-by-cycle scoreboard: grants, one-in-flight, strobe timing and
  // owner-only responses, with random fields and optional backpressure.
  task automatic run_traffic(string tag, int ncyc, bit both, bit rand_rdy);
    txn_t q[$];
    txn_t t;
    logic [1:0] exp_rdy;
    int g, n_hs, n_done;
    bit hs_now;
    n_hs = 0; n_done = 0; g = 0;
    @(posedge clk); #1;
    rsp_ready = 2'b11;
    for (int p = 0; p < 2; p++) if (both || $urandom_range(0, 1) == 1) new_req(p);
    for (int c = 0; c < ncyc + 12; c++) begin
      @(negedge clk);
      if (q.size() > 0 && cyc == q[0].hs + 1) begin
        n_checks++;
        if ({dmem_MemWrite, dmem_MemRead, dmem_address, dmem_funct3} !==
            {q[0].we & ~q[0].err, ~q[0].we & ~q[0].err, q[0].addr, q[0].f3})
          $display("FAIL %s_access got=w%b r%b a%h f%b exp=w%b r%b a%h f%b", tag, dmem_MemWrite, dmem_MemRead,
                   dmem_address, dmem_funct3, q[0].we & ~q[0].err, ~q[0].we & ~q[0].err, q[0].addr, q[0].f3);
        else n_pass++;
        if (q[0].we) begin
          n_checks++; if (dmem_rs !== q[0].wdata) $display("FAIL %s_rs got=%h exp=%h", tag, dmem_rs, q[0].wdata); else n_pass++;
        end
      end else begin
        n_checks++; if ({dmem_MemWrite, dmem_MemRead} !== 2'b00) $display("FAIL %s_idle_strobe got=%b%b exp=00", tag, dmem_MemWrite, dmem_MemRead); else n_pass++;
      end
      hs_now = 1'b0;
      if (q.size() > 0) begin
        n_checks++; if (req_ready !== 2'b00) $display("FAIL %s_busy_ready got=%b exp=00", tag, req_ready); else n_pass++;
      end else begin
        if (req_valid == 2'b11) exp_rdy = exp_last ? 2'b01 : 2'b10;
        else                    exp_rdy = req_valid;
        n_checks++; if (req_ready !== exp_rdy) $display("FAIL %s_grant got=%b exp=%b", tag, req_ready, exp_rdy); else n_pass++;
        if (exp_rdy != 2'b00) begin
          g = (exp_rdy == 2'b10) ? 1 : 0;
          t.port = g; t.we = req_we[g]; t.f3 = req_f3[g]; t.addr = req_addr[g]; t.wdata = req_wdata[g];
          t.err   = exp_reject(t.we, t.f3, t.addr);
          t.rdata = (t.we || t.err) ? 32'h0 : ref_load(t.f3, t.addr);
          if (t.we && !t.err) ref_store(t.f3, t.addr, t.wdata);
          t.hs = cyc;
          q.push_back(t);
          exp_last = g[0];
          hs_now = 1'b1;
          n_hs++;
        end
      end
      if (q.size() > 0 && cyc >= q[0].hs + 2) begin
        n_checks++;
        if (rsp_valid !== (q[0].port == 1 ? 2'b10 : 2'b01) || rsp_rdata[q[0].port] !== q[0].rdata || rsp_err[q[0].port] !== q[0].err)
          $display("FAIL %s_rsp got=v%b d%h e%b exp=port%0d d%h e%b", tag, rsp_valid, rsp_rdata[q[0].port],
                   rsp_err[q[0].port], q[0].port, q[0].rdata, q[0].err);
        else n_pass++;
        if (rsp_ready[q[0].port]) begin
          void'(q.pop_front());
          n_done++;
        end
      end else begin
        n_checks++; if (rsp_valid !== 2'b00) $display("FAIL %s_no_rsp got=%b exp=00", tag, rsp_valid); else n_pass++;
      end
      @(posedge clk); #1;
      if (hs_now) begin
        if (c < ncyc && (both || $urandom_range(0, 1) == 1)) new_req(g);
        else req_valid[g] = 1'b0;
      end
      if (c < ncyc && !both)
        for (int p = 0; p < 2; p++) if (!req_valid[p] && $urandom_range(0, 3) == 0) new_req(p);
      if (c >= ncyc) req_valid = 2'b00;
      rsp_ready = (rand_rdy && c < ncyc) ? 2'($urandom) : 2'b11;
    end
    n_checks++; if (q.size() != 0 || n_done != n_hs) $display("FAIL %s_drain got=left%0d done%0d exp=left0 done%0d", tag, q.size(), n_done, n_hs); else n_pass++;
    if (both && !rand_rdy) begin
      n_checks++; if (n_hs < ncyc / 3) $display("FAIL %s_throughput got=%0d exp>=%0d", tag, n_hs, ncyc / 3); else n_pass++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_store();
    test_loads();
    test_hold();
    test_misaligned();
    test_reset_mid();
    run_traffic("rr", 60, 1'b1, 1'b0);
    run_traffic("rand", 150, 1'b0, 1'b1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
